// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF input synchroniser, oversampled majority-vote bit recovery,
// optional parity, 1-2 stop bits and a valid/ready output register with overrun flag.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rstb_i,
    input  logic                 baud_tick_i,
    input  logic                 rxd_i,
    input  logic                 rx_ready_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_err_o,
    output logic                 busy_o
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] VOTE0     = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] VOTE1     = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] VOTE2     = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);
    localparam logic             PAR_EN    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 done_d, done_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, perr_out_q, ferr_out_q, ovr_q;
    logic                 rxd_s, bit_val, at_vote, at_end;

    assign rxd_s   = sync2_q;
    assign at_vote = (tick_cnt_q == VOTE2);
    assign at_end  = (tick_cnt_q == CNT_LAST);
    // Third vote is the live sample taken on the same tick the decision is made.
    assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            samp_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sync1_q    <= rxd_i;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        done_d     = 1'b0;
        if (baud_tick_i) begin
            if (state_q != S_IDLE && state_q != S_WAIT_IDLE) begin
                tick_cnt_d = at_end ? '0 : tick_cnt_q + 1'b1;
                if (tick_cnt_q == VOTE0) samp_d[0] = rxd_s;
                if (tick_cnt_q == VOTE1) samp_d[1] = rxd_s;
            end
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        par_err_d  = 1'b0;
                        frm_err_d  = 1'b0;
                    end
                end
                S_START: begin
                    if (at_vote && bit_val) begin
                        state_d    = S_IDLE;
                        tick_cnt_d = '0;
                    end else if (at_end) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (at_vote) begin
                        shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (at_end && bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = PAR_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (at_vote) par_err_d = (^shift_q) ^ bit_val ^ PAR_ODD;
                    if (at_end) state_d = S_STOP;
                end
                S_STOP: begin
                    // The frame completes at the midpoint of the last stop bit.
                    if (at_vote) begin
                        frm_err_d = frm_err_q | ~bit_val;
                        if (bit_cnt_q == STOP_LAST) begin
                            done_d     = 1'b1;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                            state_d    = frm_err_d ? S_WAIT_IDLE : S_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxd_s) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A completed frame is dropped only if the held word is not being accepted this edge.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done_q) begin
                if (!rx_valid_q || rx_ready_i) begin
                    rx_data_q  <= shift_q;
                    perr_out_q <= par_err_q;
                    ferr_out_q <= frm_err_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign parity_err_o  = perr_out_q;
    assign frame_err_o   = ferr_out_q;
    assign overrun_err_o = ovr_q;
    assign busy_o        = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: an 8N1 receiver and an 8E2 receiver driven
// with directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_core;
    localparam int OS = 16;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rxd [2];
    logic       rdy [2];
    logic [7:0] data [2];
    logic       vld [2];
    logic       pe [2];
    logic       fe [2];
    logic       ov [2];
    logic       busy [2];
    logic       vld_prev [2];

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_ov [2];
    int   ov_seen [2];
    int   div_cnt = 0;
    int   tick_count = 0;
    logic last_tick = 1'b0;
    logic prev_tick = 1'b0;
    int   stop_start = 0;
    bit   timing_ok = 1'b0;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk_i(clk), .rstb_i(rstb), .baud_tick_i(baud_tick), .rxd_i(rxd[0]), .rx_ready_i(rdy[0]),
        .rx_data_o(data[0]), .rx_valid_o(vld[0]), .parity_err_o(pe[0]), .frame_err_o(fe[0]),
        .overrun_err_o(ov[0]), .busy_o(busy[0])
    );

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
        .clk_i(clk), .rstb_i(rstb), .baud_tick_i(baud_tick), .rxd_i(rxd[1]), .rx_ready_i(rdy[1]),
        .rx_data_o(data[1]), .rx_valid_o(vld[1]), .parity_err_o(pe[1]), .frame_err_o(fe[1]),
        .overrun_err_o(ov[1]), .busy_o(busy[1])
    );

    always #5 clk = ~clk;

    // One baud tick every fourth clock, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            div_cnt   = (div_cnt + 1) % 4;
            baud_tick = (div_cnt == 0);
        end
    end

    always @(posedge clk) begin
        if (baud_tick) tick_count <= tick_count + 1;
        last_tick <= baud_tick;
        prev_tick <= last_tick;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (baud_tick) k++;
        end
    endtask

    task automatic drive_bit(input int u, input logic b);
        #1;
        rxd[u] = b;
        wait_ticks(OS);
    endtask

    // Frame model: even parity on dut1, frame error whenever the first stop bit is low.
    task automatic send_frame(input int u, input logic [7:0] d, input bit pflip,
                              input int stop_low, input int gap, input bit push);
        exp_t e;
        logic pbit;
        int   nstop;
        nstop = (u == 1) ? 2 : 1;
        pbit  = (($countones(d) % 2) == 1) ^ pflip;
        e.d   = d;
        e.pe  = (u == 1) && ((($countones(d) + 32'(pbit)) % 2) != 0);
        e.fe  = (stop_low > 0);
        if (push) begin
            if (u == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        if (u == 0) timing_ok = (stop_low == 0);
        wait_ticks(1);
        drive_bit(u, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(u, d[i]);
        if (u == 1) drive_bit(u, pbit);
        for (int i = 0; i < stop_low; i++) drive_bit(u, 1'b0);
        #1;
        if (u == 0) stop_start = tick_count;
        for (int i = 0; i < nstop + gap; i++) drive_bit(u, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s dut%0d data", tag, u), 32'(data[u]), 32'd0);
            check($sformatf("%s dut%0d valid", tag, u), 32'(vld[u]), 32'd0);
            check($sformatf("%s dut%0d parity_err", tag, u), 32'(pe[u]), 32'd0);
            check($sformatf("%s dut%0d frame_err", tag, u), 32'(fe[u]), 32'd0);
            check($sformatf("%s dut%0d overrun", tag, u), 32'(ov[u]), 32'd0);
            check($sformatf("%s dut%0d busy", tag, u), 32'(busy[u]), 32'd0);
        end
    endtask

    // Monitor: pops the model whenever a word is handed over (valid and ready).
    initial begin
        exp_t e;
        bit   have;
        int   offs;
        vld_prev[0] = 1'b0;
        vld_prev[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (rstb) begin
                for (int u = 0; u < 2; u++) begin
                    if (ov[u]) ov_seen[u]++;
                    if (u == 0 && vld[0] && !vld_prev[0] && timing_ok) begin
                        offs = tick_count - stop_start;
                        check("valid one clk after tick", 32'(prev_tick & ~last_tick), 32'd1);
                        check("valid at stop midpoint", 32'((offs >= OS/2 - 1) && (offs <= OS/2 + 3)), 32'd1);
                    end
                    if (vld[u] && rdy[u]) begin
                        have = 1'b0;
                        if (u == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                        if (u == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                        check($sformatf("dut%0d word expected by model", u), 32'(have), 32'd1);
                        if (have)
                            check($sformatf("dut%0d word/perr/ferr", u), 32'({data[u], pe[u], fe[u]}),
                                  32'({e.d, e.pe, e.fe}));
                    end
                end
            end
            vld_prev[0] = vld[0];
            vld_prev[1] = vld[1];
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int u;
        int sl;
        exp_ov[0] = 0; exp_ov[1] = 0;
        ov_seen[0] = 0; ov_seen[1] = 0;
        rxd[0] = 1'b1; rxd[1] = 1'b1;
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("power-on reset");
        rstb = 1'b1;
        repeat (8) @(posedge clk);

        send_frame(0, 8'hA5, 1'b0, 0, 1, 1'b1);
        send_frame(1, 8'h03, 1'b1, 0, 1, 1'b1);
        send_frame(1, 8'h03, 1'b0, 0, 1, 1'b1);

        // Quarter-bit glitch on an idle line
        wait_ticks(1);
        #1 rxd[0] = 1'b0;
        wait_ticks(OS / 4);
        #1 rxd[0] = 1'b1;
        wait_ticks(2);
        #1 check("busy during glitch", 32'(busy[0]), 32'd1);
        wait_ticks(OS - OS / 4 - 2);
        #1 check("busy after glitch", 32'(busy[0]), 32'd0);
        check("valid after glitch", 32'(vld[0]), 32'd0);

        send_frame(0, 8'h55, 1'b0, 3, 2, 1'b1);
        send_frame(0, 8'h3C, 1'b0, 0, 1, 1'b1);

        for (int n = 0; n < 24; n++) begin
            u  = 32'($urandom_range(0, 1));
            sl = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 2)) : 0;
            send_frame(u, 8'($urandom), 1'($urandom_range(0, 1)), sl, 32'($urandom_range(0, 2)), 1'b1);
        end

        // Overrun: second word arrives while the first is still held
        rdy[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 0, 1, 1'b1);
        send_frame(0, 8'h22, 1'b0, 0, 1, 1'b0);
        exp_ov[0]++;
        #1 check("held data", 32'(data[0]), 32'h11);
        check("held valid", 32'(vld[0]), 32'd1);
        rdy[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("valid cleared after accept", 32'(vld[0]), 32'd0);

        // Reset during data bit 4 of 0xFF
        wait_ticks(1);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        #1 rxd[0] = 1'b1;
        wait_ticks(OS / 2);
        #1 check("busy mid-frame", 32'(busy[0]), 32'd1);
        rstb = 1'b0;
        #1 check_reset_outputs("mid-frame reset");
        repeat (5) @(posedge clk);
        #1 rstb = 1'b1;
        repeat (4) @(posedge clk);
        send_frame(0, 8'h42, 1'b0, 0, 1, 1'b1);

        wait_ticks(2 * OS);
        #1;
        check("dut0 model words left", 32'(q0.size()), 32'd0);
        check("dut1 model words left", 32'(q1.size()), 32'd0);
        check("dut0 overrun pulses", 32'(ov_seen[0]), 32'(exp_ov[0]));
        check("dut1 overrun pulses", 32'(ov_seen[1]), 32'(exp_ov[1]));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
